// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle datapath control unit.
// Ports: none (package).
// Holds the controller state enum, opcode/ALU encodings and the output bundle.
package ctrl_pkg;

  localparam int CTRL_ALU_OP_W = 3;
  localparam int CTRL_OPCODE_W = 3;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEM_RD = 4'd2,
    WB_MEM = 4'd3,
    MEM_WR = 4'd4,
    JMP    = 4'd5,
    BR     = 4'd6,
    EXE_R  = 4'd7,
    EXE_I  = 4'd8,
    WB_ALU = 4'd9
  } state_t;

  localparam logic [CTRL_OPCODE_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [CTRL_OPCODE_W-1:0] OP_STORE = 3'b001;
  localparam logic [CTRL_OPCODE_W-1:0] OP_JUMP  = 3'b010;
  localparam logic [CTRL_OPCODE_W-1:0] OP_BZ    = 3'b011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_ALU   = 3'b100;
  localparam logic [CTRL_OPCODE_W-1:0] OP_ADDI  = 3'b101;

  localparam logic [CTRL_ALU_OP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_AND   = 3'b010;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_OR    = 3'b011;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_NOT   = 3'b100;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_PASSB = 3'b101;

  // Every control line the datapath consumes, in one packed bundle.
  typedef struct packed {
    logic                     pc_write;
    logic                     pc_write_cond;
    logic                     ir_write;
    logic                     mem_read;
    logic                     mem_write;
    logic                     sel_adr_pc;
    logic                     sel_adr_ir;
    logic                     sel_alu_reg;
    logic                     sel_alu_imm;
    logic                     sel_dst_ir;
    logic                     sel_dst_r0;
    logic                     sel_wr_alu;
    logic                     sel_wr_mem;
    logic                     sel_wr_imm;
    logic                     rf_write;
    logic [CTRL_ALU_OP_W-1:0] alu_op;
    logic                     busy;
  } ctrl_out_t;

  // Reg-reg function field to ALU operation; the two unused codes fall back to add.
  function automatic logic [CTRL_ALU_OP_W-1:0] func_to_alu(input logic [2:0] f);
    return (f > ALU_PASSB) ? ALU_ADD : f;
  endfunction

endpackage

// File: rtl/ctrl_output_decoder.sv
// Purpose: state -> control bundle decode; the only place selects are driven.
// Latency: combinational, zero cycles.
// Backpressure: mem_ready only gates the FETCH-cycle IR/PC loads.
// Ports: i_state (current FSM state), i_func (IR[12:10]), i_mem_ready, o_ctrl (bundle).
module ctrl_output_decoder
  import ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_func,
  input  logic       i_mem_ready,
  output ctrl_out_t  o_ctrl
);

  always_comb begin
    o_ctrl      = '0;
    o_ctrl.busy = 1'b1;
    unique case (i_state)
      FETCH: begin
        o_ctrl.busy       = 1'b0;
        o_ctrl.sel_adr_pc = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.alu_op     = ALU_ADD;
        // IR and PC+1 only commit on the cycle the instruction word is delivered.
        o_ctrl.ir_write   = i_mem_ready;
        o_ctrl.pc_write   = i_mem_ready;
      end
      DECODE: ;
      MEM_RD: begin
        o_ctrl.sel_adr_ir = 1'b1;
        o_ctrl.mem_read   = 1'b1;
      end
      WB_MEM: begin
        o_ctrl.sel_wr_mem = 1'b1;
        o_ctrl.sel_dst_r0 = 1'b1;
        o_ctrl.rf_write   = 1'b1;
      end
      MEM_WR: begin
        o_ctrl.sel_adr_ir = 1'b1;
        o_ctrl.mem_write  = 1'b1;
      end
      JMP: o_ctrl.pc_write = 1'b1;
      BR: begin
        // The zero-flag qualification of the branch happens in the datapath.
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.sel_alu_reg   = 1'b1;
        o_ctrl.pc_write_cond = 1'b1;
      end
      EXE_R: begin
        o_ctrl.sel_alu_reg = 1'b1;
        o_ctrl.alu_op      = func_to_alu(i_func);
      end
      EXE_I: begin
        o_ctrl.sel_alu_imm = 1'b1;
        o_ctrl.alu_op      = ALU_ADD;
      end
      WB_ALU: begin
        o_ctrl.sel_wr_alu = 1'b1;
        o_ctrl.sel_dst_ir = 1'b1;
        o_ctrl.rf_write   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: control FSM for the 8-bit multicycle datapath (state register + next state).
// Latency: LOAD/ALU 4 cycles, STORE/JUMP/BZ 3, NOP 2 with memory always ready.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until mem_ready; reset forces all lines low.
// Ports: clk, rst (sync, active high), opcode, func, zero, mem_ready in;
//        PC/IR/memory/RF enables, mux selects, alu_op and busy out.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [2:0]              func,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    ir_write,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    sel_adr_pc,
  output logic                    sel_adr_ir,
  output logic                    sel_alu_reg,
  output logic                    sel_alu_imm,
  output logic                    sel_dst_ir,
  output logic                    sel_dst_r0,
  output logic                    sel_wr_alu,
  output logic                    sel_wr_mem,
  output logic                    sel_wr_imm,
  output logic                    rf_write,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    busy
);

  state_t    r_state;
  state_t    w_next;
  ctrl_out_t w_dec;
  ctrl_out_t w_out;
  logic      w_zero_unused;

  // The branch decision is taken by the datapath from pc_write_cond & zero.
  assign w_zero_unused = zero;

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    unique case (r_state)
      FETCH:  w_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LOAD:  w_next = MEM_RD;
          OP_STORE: w_next = MEM_WR;
          OP_JUMP:  w_next = JMP;
          OP_BZ:    w_next = BR;
          OP_ALU:   w_next = EXE_R;
          OP_ADDI:  w_next = EXE_I;
          default:  w_next = FETCH;  // 11x decodes as a no-op
        endcase
      end
      MEM_RD: w_next = mem_ready ? WB_MEM : MEM_RD;
      WB_MEM: w_next = FETCH;
      MEM_WR: w_next = mem_ready ? FETCH : MEM_WR;
      JMP:    w_next = FETCH;
      BR:     w_next = FETCH;
      EXE_R:  w_next = WB_ALU;
      EXE_I:  w_next = WB_ALU;
      WB_ALU: w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  ctrl_output_decoder u_dec (
    .i_state     (r_state),
    .i_func      (func),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_dec)
  );

  // Reset masks the bundle so an access in flight is dropped without a write.
  assign w_out = rst ? '0 : w_dec;

  assign pc_write      = w_out.pc_write;
  assign pc_write_cond = w_out.pc_write_cond;
  assign ir_write      = w_out.ir_write;
  assign mem_read      = w_out.mem_read;
  assign mem_write     = w_out.mem_write;
  assign sel_adr_pc    = w_out.sel_adr_pc;
  assign sel_adr_ir    = w_out.sel_adr_ir;
  assign sel_alu_reg   = w_out.sel_alu_reg;
  assign sel_alu_imm   = w_out.sel_alu_imm;
  assign sel_dst_ir    = w_out.sel_dst_ir;
  assign sel_dst_r0    = w_out.sel_dst_r0;
  assign sel_wr_alu    = w_out.sel_wr_alu;
  assign sel_wr_mem    = w_out.sel_wr_mem;
  assign sel_wr_imm    = w_out.sel_wr_imm;
  assign rf_write      = w_out.rf_write;
  assign alu_op        = ALU_OP_WIDTH'(w_out.alu_op);
  assign busy          = w_out.busy;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed step table, reset-abort sequence,
// and a randomized run against an instruction-script reference model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write;
    logic       sel_adr_pc, sel_adr_ir, sel_alu_reg, sel_alu_imm;
    logic       sel_dst_ir, sel_dst_r0, sel_wr_alu, sel_wr_mem, sel_wr_imm;
    logic       rf_write;
    logic [2:0] alu_op;
    logic       busy;
  } ov_t;

  // Step labels of an instruction script (what the bench expects, not a state code).
  localparam int S_RST = 0, S_F = 1, S_D = 2, S_MR = 3, S_WM = 4, S_MW = 5,
                 S_J = 6, S_B = 7, S_ER = 8, S_EI = 9, S_WA = 10;

  typedef struct {
    int         step;
    logic       rst;
    logic [2:0] op;
    logic [2:0] fn;
    logic       z;
    logic       mr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] opcode = '0, func = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, pc_write_cond, ir_write, mem_read, mem_write;
  logic sel_adr_pc, sel_adr_ir, sel_alu_reg, sel_alu_imm, sel_dst_ir, sel_dst_r0;
  logic sel_wr_alu, sel_wr_mem, sel_wr_imm, rf_write, busy;
  logic [2:0] alu_op;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ALU_OP_WIDTH(3), .OPCODE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .sel_adr_pc(sel_adr_pc), .sel_adr_ir(sel_adr_ir), .sel_alu_reg(sel_alu_reg),
    .sel_alu_imm(sel_alu_imm), .sel_dst_ir(sel_dst_ir), .sel_dst_r0(sel_dst_r0),
    .sel_wr_alu(sel_wr_alu), .sel_wr_mem(sel_wr_mem), .sel_wr_imm(sel_wr_imm),
    .rf_write(rf_write), .alu_op(alu_op), .busy(busy)
  );

  ov_t dut_o;
  assign dut_o = '{pc_write, pc_write_cond, ir_write, mem_read, mem_write,
                   sel_adr_pc, sel_adr_ir, sel_alu_reg, sel_alu_imm,
                   sel_dst_ir, sel_dst_r0, sel_wr_alu, sel_wr_mem, sel_wr_imm,
                   rf_write, alu_op, busy};

  // Expected control lines for one step of an instruction.
  function automatic ov_t exp_out(input int step, input logic [2:0] fn, input logic mr);
    ov_t o;
    o = '0;
    o.busy = (step != S_F) && (step != S_RST);
    case (step)
      S_F:  begin o.sel_adr_pc = 1; o.mem_read = 1; o.ir_write = mr; o.pc_write = mr; end
      S_MR: begin o.sel_adr_ir = 1; o.mem_read = 1; end
      S_WM: begin o.sel_wr_mem = 1; o.sel_dst_r0 = 1; o.rf_write = 1; end
      S_MW: begin o.sel_adr_ir = 1; o.mem_write = 1; end
      S_J:  o.pc_write = 1;
      S_B:  begin o.alu_op = 3'b001; o.sel_alu_reg = 1; o.pc_write_cond = 1; end
      S_ER: begin o.sel_alu_reg = 1; o.alu_op = (fn >= 3'd6) ? 3'b000 : fn; end
      S_EI: o.sel_alu_imm = 1;
      S_WA: begin o.sel_wr_alu = 1; o.sel_dst_ir = 1; o.rf_write = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(input string nm, input ov_t exp);
    n_chk++;
    if (dut_o !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (t=%0t)", nm, dut_o, exp, $time);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (t=%0t)", nm, got, req, $time);
    end
  endtask

  task automatic chk_onehot();
    n_chk++;
    if ($countones({sel_adr_pc, sel_adr_ir}) > 1 ||
        $countones({sel_alu_reg, sel_alu_imm}) > 1 ||
        $countones({sel_dst_ir, sel_dst_r0}) > 1 ||
        $countones({sel_wr_alu, sel_wr_mem, sel_wr_imm}) > 1) begin
      n_fail++;
      $display("FAIL onehot: selects %b required at most one per group (t=%0t)",
               {sel_adr_pc, sel_adr_ir, sel_alu_reg, sel_alu_imm, sel_dst_ir,
                sel_dst_r0, sel_wr_alu, sel_wr_mem, sel_wr_imm}, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] op, input logic [2:0] fn,
                       input logic z, input logic mr);
    @(negedge clk);
    rst = r; opcode = op; func = fn; zero = z; mem_ready = mr;
    #1;
  endtask

  function automatic vec_t v(input int step, input logic [2:0] op = 3'd0,
                             input logic [2:0] fn = 3'd0, input logic z = 1'b0,
                             input logic mr = 1'b1);
    vec_t t;
    t.step = step; t.rst = 1'b0; t.op = op; t.fn = fn; t.z = z; t.mr = mr;
    return t;
  endfunction

  // Reference: remaining steps of the current instruction, filled at decode.
  int cur;
  int q[$];

  function automatic void load_script(input logic [2:0] op);
    q.delete();
    case (op)
      3'd0: q = '{S_MR, S_WM};
      3'd1: q = '{S_MW};
      3'd2: q = '{S_J};
      3'd3: q = '{S_B};
      3'd4: q = '{S_ER, S_WA};
      3'd5: q = '{S_EI, S_WA};
      default: ;
    endcase
  endfunction

  function automatic int next_step();
    return (q.size() != 0) ? q.pop_front() : S_F;
  endfunction

  initial begin
    vec_t tbl[$];
    logic r, z, mr;
    logic [2:0] op, fn;
    ov_t e;

    // Reset state
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
    chk("reset_outputs", '0);

    // LOAD, STORE, JUMP, BZ x2, ALU x2, ADDI, NOP x2, fetch stall, load stall, store stall
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd0)); tbl.push_back(v(S_MR)); tbl.push_back(v(S_WM));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd1)); tbl.push_back(v(S_MW));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd2)); tbl.push_back(v(S_J));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd3)); tbl.push_back(v(S_B, 3'd3, 3'd0, 1'b1));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd3)); tbl.push_back(v(S_B, 3'd3, 3'd0, 1'b0));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd4, 3'd3)); tbl.push_back(v(S_ER, 3'd4, 3'd3)); tbl.push_back(v(S_WA));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd4, 3'd7)); tbl.push_back(v(S_ER, 3'd4, 3'd7)); tbl.push_back(v(S_WA));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd5)); tbl.push_back(v(S_EI)); tbl.push_back(v(S_WA));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd6));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd7));
    for (int i = 0; i < 3; i++) tbl.push_back(v(S_F, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd0));
    tbl.push_back(v(S_MR, 3'd0, 3'd0, 1'b0, 1'b0)); tbl.push_back(v(S_MR, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(S_MR)); tbl.push_back(v(S_WM));
    tbl.push_back(v(S_F));  tbl.push_back(v(S_D, 3'd1));
    tbl.push_back(v(S_MW, 3'd1, 3'd0, 1'b0, 1'b0)); tbl.push_back(v(S_MW, 3'd1, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(S_MW));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].mr);
      chk($sformatf("table[%0d]", i), exp_out(tbl[i].step, tbl[i].fn, tbl[i].mr));
      chk_onehot();
    end

    // Reset in the middle of a stalled store: the write is dropped.
    drive(1'b0, 3'd1, 3'd0, 1'b0, 1'b1); chk("abort_fetch", exp_out(S_F, 3'd0, 1'b1));
    drive(1'b0, 3'd1, 3'd0, 1'b0, 1'b1); chk("abort_decode", exp_out(S_D, 3'd0, 1'b1));
    drive(1'b0, 3'd1, 3'd0, 1'b0, 1'b0); chk_bit("abort_mw_before", mem_write, 1'b1);
    drive(1'b1, 3'd1, 3'd0, 1'b0, 1'b0); chk_bit("abort_rst1_mem_write", mem_write, 1'b0);
    chk("abort_rst1_all", '0);
    drive(1'b1, 3'd1, 3'd0, 1'b0, 1'b0); chk_bit("abort_rst2_mem_write", mem_write, 1'b0);
    drive(1'b0, 3'd1, 3'd0, 1'b0, 1'b0);
    chk_bit("release_sel_adr_pc", sel_adr_pc, 1'b1);
    chk_bit("release_mem_read", mem_read, 1'b1);
    chk_bit("release_busy", busy, 1'b0);
    chk("release_fetch", exp_out(S_F, 3'd0, 1'b0));

    // Randomized run against the script model; state is FETCH (stalled) here.
    cur = S_F;
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      op = 3'($urandom_range(0, 7));
      fn = 3'($urandom_range(0, 7));
      z  = 1'($urandom_range(0, 1));
      mr = ($urandom_range(0, 3) != 0);
      drive(r, op, fn, z, mr);
      e = r ? ov_t'('0) : exp_out(cur, fn, mr);
      chk("random", e);
      chk_onehot();
      if (r) begin
        cur = S_F;
        q.delete();
      end else begin
        case (cur)
          S_F:        if (mr) cur = S_D;
          S_D:        begin load_script(op); cur = next_step(); end
          S_MR, S_MW: if (mr) cur = next_step();
          default:    cur = next_step();
        endcase
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
